// File: rtl/regfile_sb_if.sv
// Bundle of register-file read, write and scoreboard signals shared by the
// issuing pipeline (master) and the register file (slave).
interface regfile_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rsc;
   logic [ADDR_W-1:0] rtc;
   logic [DATA_W-1:0] rs;
   logic [DATA_W-1:0] rt;
   logic              rs_busy;
   logic              rt_busy;
   logic              wa_en;
   logic [ADDR_W-1:0] wa_addr;
   logic [DATA_W-1:0] wa_data;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;
   logic [ADDR_W:0]   busy_cnt;

   modport master (
      output rsc, rtc,
      output wa_en, wa_addr, wa_data,
      output wb_en, wb_addr, wb_data,
      output rsv_en, rsv_addr,
      input  rs, rt, rs_busy, rt_busy, busy_cnt
   );

   modport slave (
      input  rsc, rtc,
      input  wa_en, wa_addr, wa_data,
      input  wb_en, wb_addr, wb_data,
      input  rsv_en, rsv_addr,
      output rs, rt, rs_busy, rt_busy, busy_cnt
   );
endinterface

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with optional same-cycle forwarding and a
// per-register busy scoreboard for long-latency results (reserve / release).
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   regfile_sb_if.slave   rf
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic [ADDR_W:0]   busy_cnt_q;

   logic              wa_ok;
   logic              wb_ok;
   logic              rsv_ok;

   logic [ADDR_W-1:0] raddr [2];
   logic [DATA_W-1:0] rdata [2];
   logic              rbusy [2];

   function automatic logic writable(input logic [ADDR_W-1:0] a);
      return (ZERO_REG == 0) || (a != '0);
   endfunction

   function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
      logic [ADDR_W:0] n;
      n = '0;
      for (int i = 0; i < DEPTH; i++) begin
         n = n + {{ADDR_W{1'b0}}, v[i]};
      end
      return n;
   endfunction

   assign wa_ok  = rf.wa_en  && writable(rf.wa_addr);
   assign wb_ok  = rf.wb_en  && writable(rf.wb_addr);
   assign rsv_ok = rf.rsv_en && writable(rf.rsv_addr);

   // Storage: port B first so a same-address port A write overrides it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (wb_ok) begin
            regs[rf.wb_addr] <= rf.wb_data;
         end
         if (wa_ok) begin
            regs[rf.wa_addr] <= rf.wa_data;
         end
      end
   end

   // Release is applied before reserve so a same-cycle reservation wins.
   always_comb begin
      busy_nxt = busy;
      if (rf.wb_en) begin
         busy_nxt[rf.wb_addr] = 1'b0;
      end
      if (rsv_ok) begin
         busy_nxt[rf.rsv_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= '0;
         busy_cnt_q <= '0;
      end else begin
         busy       <= busy_nxt;
         busy_cnt_q <= popcount(busy_nxt);
      end
   end

   assign raddr[0] = rf.rsc;
   assign raddr[1] = rf.rtc;

   // Read ports: zero register, then port A, then port B, then storage.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = regs[raddr[p]];
         rbusy[p] = busy[raddr[p]];
         if (BYPASS != 0) begin
            if (rf.wb_en && (rf.wb_addr == raddr[p])) begin
               rbusy[p] = 1'b0;
            end
            if (wb_ok && (rf.wb_addr == raddr[p])) begin
               rdata[p] = rf.wb_data;
            end
            if (wa_ok && (rf.wa_addr == raddr[p])) begin
               rdata[p] = rf.wa_data;
            end
         end
         if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
            rdata[p] = '0;
            rbusy[p] = 1'b0;
         end
         if (!rst_n) begin
            rdata[p] = '0;
            rbusy[p] = 1'b0;
         end
      end
   end

   assign rf.rs       = rdata[0];
   assign rf.rt       = rdata[1];
   assign rf.rs_busy  = rbusy[0];
   assign rf.rt_busy  = rbusy[1];
   assign rf.busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (zero-reg + bypass, and plain) driven in
// lockstep and compared against an array-based reference of the register file.
module tb_regfile_sb;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DEPTH = 1 << AW;

   logic clk;
   logic rst_n;

   logic [AW-1:0] rsc, rtc, wa_addr, wb_addr, rsv_addr;
   logic [DW-1:0] wa_data, wb_data;
   logic          wa_en, wb_en, rsv_en;

   int checks;
   int failures;

   // Reference state, index 0: ZERO_REG=1/BYPASS=1, index 1: ZERO_REG=0/BYPASS=0
   logic [DW-1:0] m_reg  [2][DEPTH];
   bit            m_busy [2][DEPTH];

   regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
   regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .rf(bus0)
   );
   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .rf(bus1)
   );

   assign bus0.rsc = rsc;          assign bus1.rsc = rsc;
   assign bus0.rtc = rtc;          assign bus1.rtc = rtc;
   assign bus0.wa_en = wa_en;      assign bus1.wa_en = wa_en;
   assign bus0.wa_addr = wa_addr;  assign bus1.wa_addr = wa_addr;
   assign bus0.wa_data = wa_data;  assign bus1.wa_data = wa_data;
   assign bus0.wb_en = wb_en;      assign bus1.wb_en = wb_en;
   assign bus0.wb_addr = wb_addr;  assign bus1.wb_addr = wb_addr;
   assign bus0.wb_data = wb_data;  assign bus1.wb_data = wb_data;
   assign bus0.rsv_en = rsv_en;    assign bus1.rsv_en = rsv_en;
   assign bus0.rsv_addr = rsv_addr; assign bus1.rsv_addr = rsv_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit zr(input int c);
      return c == 0;
   endfunction

   function automatic bit wr_ok(input int c, input logic [AW-1:0] a);
      return !zr(c) || (a != 0);
   endfunction

   function automatic logic [DW-1:0] exp_data(input int c, input logic [AW-1:0] a);
      if (!rst_n) return '0;
      if (zr(c) && a == 0) return '0;
      if (c == 0) begin
         if (wa_en && wa_addr == a && wr_ok(c, a)) return wa_data;
         if (wb_en && wb_addr == a && wr_ok(c, a)) return wb_data;
      end
      return m_reg[c][a];
   endfunction

   function automatic bit exp_busy(input int c, input logic [AW-1:0] a);
      if (!rst_n) return 1'b0;
      if (zr(c) && a == 0) return 1'b0;
      if (c == 0 && wb_en && wb_addr == a) return 1'b0;
      return m_busy[c][a];
   endfunction

   function automatic int exp_cnt(input int c);
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(m_busy[c][i]);
      return n;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int c = 0; c < 2; c++)
         for (int i = 0; i < DEPTH; i++) begin
            m_reg[c][i]  = '0;
            m_busy[c][i] = 1'b0;
         end
   endtask

   task automatic update_model();
      for (int c = 0; c < 2; c++) begin
         if (wb_en && wr_ok(c, wb_addr)) m_reg[c][wb_addr] = wb_data;
         if (wa_en && wr_ok(c, wa_addr)) m_reg[c][wa_addr] = wa_data;
         if (wb_en) m_busy[c][wb_addr] = 1'b0;
         if (rsv_en && wr_ok(c, rsv_addr)) m_busy[c][rsv_addr] = 1'b1;
      end
   endtask

   task automatic settle();
      #1;
      for (int c = 0; c < 2; c++) begin
         check($sformatf("rs_c%0d_a%0d", c, rsc),
               {32'd0, (c == 0) ? bus0.rs : bus1.rs}, {32'd0, exp_data(c, rsc)});
         check($sformatf("rt_c%0d_a%0d", c, rtc),
               {32'd0, (c == 0) ? bus0.rt : bus1.rt}, {32'd0, exp_data(c, rtc)});
         check($sformatf("rs_busy_c%0d_a%0d", c, rsc),
               {63'd0, (c == 0) ? bus0.rs_busy : bus1.rs_busy}, {63'd0, exp_busy(c, rsc)});
         check($sformatf("rt_busy_c%0d_a%0d", c, rtc),
               {63'd0, (c == 0) ? bus0.rt_busy : bus1.rt_busy}, {63'd0, exp_busy(c, rtc)});
         check($sformatf("busy_cnt_c%0d", c),
               {58'd0, (c == 0) ? bus0.busy_cnt : bus1.busy_cnt}, 64'(exp_cnt(c)));
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      if (rst_n) update_model();
      @(negedge clk);
   endtask

   task automatic idle();
      wa_en = 1'b0; wb_en = 1'b0; rsv_en = 1'b0;
      wa_addr = '0; wb_addr = '0; rsv_addr = '0;
      wa_data = '0; wb_data = '0;
   endtask

   task automatic sweep();
      idle();
      for (int a = 0; a < DEPTH; a += 2) begin
         rsc = AW'(a); rtc = AW'(a + 1);
         settle();
         edge_step();
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b1;
      rsc = '0; rtc = '0;
      idle();
      clear_model();
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rsc = 5'd5; rtc = 5'd0;
      settle();
      rst_n = 1'b1;

      // Write r5 and reserve r6, then reset mid-stream
      wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
      rsv_en = 1; rsv_addr = 6;
      settle(); edge_step();
      idle(); rsc = 5; rtc = 6;
      settle();
      check("r5_before_reset", {32'd0, bus1.rs}, 64'hDEADBEEF);
      #2 rst_n = 1'b0;
      clear_model();
      settle();
      check("reset_rs0", {32'd0, bus0.rs}, 64'd0);
      check("reset_cnt0", {58'd0, bus0.busy_cnt}, 64'd0);
      check("reset_rs1", {32'd0, bus1.rs}, 64'd0);
      edge_step(); settle(); edge_step();
      rst_n = 1'b1;
      settle();

      // Forwarding
      wa_en = 1; wa_addr = 7; wa_data = 32'h12345678; rsc = 7; rtc = 5;
      settle();
      check("fwd_bypass", {32'd0, bus0.rs}, 64'h12345678);
      check("fwd_nobypass_old", {32'd0, bus1.rs}, 64'd0);
      edge_step();
      idle(); settle();
      check("fwd_nobypass_next", {32'd0, bus1.rs}, 64'h12345678);
      edge_step();

      // Port conflict
      wa_en = 1; wa_addr = 9; wa_data = 32'hAAAA0000;
      wb_en = 1; wb_addr = 9; wb_data = 32'h5555FFFF; rsc = 9; rtc = 9;
      settle(); edge_step();
      idle(); settle();
      check("conflict_c0", {32'd0, bus0.rs}, 64'hAAAA0000);
      check("conflict_c1", {32'd0, bus1.rt}, 64'hAAAA0000);
      edge_step();

      // Scoreboard on r3
      rsv_en = 1; rsv_addr = 3; rsc = 3; rtc = 4;
      settle(); edge_step();
      idle(); settle();
      check("sb_busy", {63'd0, bus0.rs_busy}, 64'd1);
      check("sb_cnt", {58'd0, bus0.busy_cnt}, 64'd1);
      edge_step();
      wa_en = 1; wa_addr = 3; wa_data = 32'h77;
      settle(); edge_step();
      idle(); settle();
      check("sb_waw_busy", {63'd0, bus0.rs_busy}, 64'd1);
      check("sb_waw_data", {32'd0, bus0.rs}, 64'h77);
      edge_step();
      wb_en = 1; wb_addr = 3; wb_data = 32'h42;
      settle();
      check("sb_rel_data", {32'd0, bus0.rs}, 64'h42);
      check("sb_rel_busy", {63'd0, bus0.rs_busy}, 64'd0);
      check("sb_rel_busy_nobyp", {63'd0, bus1.rs_busy}, 64'd1);
      edge_step();
      idle(); settle();
      check("sb_rel_cnt", {58'd0, bus0.busy_cnt}, 64'd0);
      edge_step();

      // Reserve + release of r4 in the same cycle
      rsv_en = 1; rsv_addr = 4; rsc = 4; rtc = 3;
      settle(); edge_step();
      rsv_en = 1; rsv_addr = 4; wb_en = 1; wb_addr = 4; wb_data = 32'h4444;
      settle(); edge_step();
      idle(); settle();
      check("rr_busy", {63'd0, bus0.rs_busy}, 64'd1);
      check("rr_cnt", {58'd0, bus0.busy_cnt}, 64'd1);
      edge_step();
      wb_en = 1; wb_addr = 4; wb_data = 32'h4;
      settle(); edge_step();

      // Zero register
      idle();
      wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF;
      wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
      rsv_en = 1; rsv_addr = 0; rsc = 0; rtc = 1;
      settle();
      check("zr_rs_same", {32'd0, bus0.rs}, 64'd0);
      edge_step();
      idle(); settle();
      check("zr_rs", {32'd0, bus0.rs}, 64'd0);
      check("zr_busy", {63'd0, bus0.rs_busy}, 64'd0);
      check("zr_cnt", {58'd0, bus0.busy_cnt}, 64'd0);
      check("zr_off_r0", {32'd0, bus1.rs}, 64'hFFFFFFFF);
      edge_step();
      sweep();

      // Reserve every register: full count only without a zero register
      for (int a = 0; a < DEPTH; a++) begin
         rsv_en = 1; rsv_addr = AW'(a); rsc = AW'(a);
         settle(); edge_step();
      end
      idle(); settle();
      check("full_cnt_c0", {58'd0, bus0.busy_cnt}, 64'd31);
      check("full_cnt_c1", {58'd0, bus1.busy_cnt}, 64'd32);
      edge_step();
      sweep();

      // Random traffic against the reference
      for (int n = 0; n < 400; n++) begin
         wa_en    = ($urandom_range(0, 3) != 0);
         wb_en    = ($urandom_range(0, 2) == 0);
         rsv_en   = ($urandom_range(0, 2) == 0);
         wa_addr  = AW'($urandom_range(0, DEPTH - 1));
         wb_addr  = ($urandom_range(0, 3) == 0) ? wa_addr : AW'($urandom_range(0, DEPTH - 1));
         rsv_addr = ($urandom_range(0, 3) == 0) ? wb_addr : AW'($urandom_range(0, DEPTH - 1));
         wa_data  = $urandom;
         wb_data  = $urandom;
         rsc      = ($urandom_range(0, 1) != 0) ? wa_addr : AW'($urandom_range(0, DEPTH - 1));
         rtc      = ($urandom_range(0, 1) != 0) ? wb_addr : AW'($urandom_range(0, DEPTH - 1));
         settle();
         edge_step();
      end
      sweep();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU register file: DATA_W x 2^ADDR_W storage with two combinational read ports and two write ports.
- Write port A is the main writeback path. Write port B is the completion path of multi-cycle units such as mult/div.
- Optional same-cycle write-to-read forwarding.
- A per-register busy scoreboard with a reserve/release handshake, so the decode stage can stall on pending long-latency results.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth is 2^ADDR_W
- ZERO_REG, 1, if 1, register 0 always reads 0 and can never be written or reserved
- BYPASS, 1, if 1, same-cycle writes are forwarded to the read ports and clear the read busy flags

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rsc  in  ADDR_W  read port S address
- rtc  in  ADDR_W  read port T address
- rs  out  DATA_W  read port S data
- rt  out  DATA_W  read port T data
- rs_busy  out  1  register at rsc has a pending reservation
- rt_busy  out  1  register at rtc has a pending reservation
- wa_en  in  1  write port A enable
- wa_addr  in  ADDR_W  write port A address
- wa_data  in  DATA_W  write port A data
- wb_en  in  1  write port B enable; also releases the reservation on wb_addr
- wb_addr  in  ADDR_W  write port B address
- wb_data  in  DATA_W  write port B data
- rsv_en  in  1  reserve request
- rsv_addr  in  ADDR_W  register to mark busy
- busy_cnt  out  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers cleared to 0, all busy bits cleared, busy_cnt = 0
  - rs/rt = 0 for every address while reset is held
  - takes effect mid-operation: any pending reservation is discarded
- Writes (at posedge clk):
  - port A: if wa_en and the address is writable, reg[wa_addr] <= wa_data
  - port B: likewise for wb_data
  - both ports, same address: port A data wins
  - "writable": address is nonzero, or ZERO_REG = 0
  - ZERO_REG = 1: writes to address 0 are silently dropped, with no effect on any other register
- Reads: combinational.
  - BYPASS = 0: rs = reg[rsc]; the new value is visible the cycle after the write
  - BYPASS = 1 priority, highest first:
    - ZERO_REG = 1 and rsc = 0 → 0
    - wa_en and wa_addr = rsc (writable) → wa_data
    - wb_en and wb_addr = rsc (writable) → wb_data
    - otherwise reg[rsc]
  - rt behaves identically on rtc.
- Scoreboard, busy[i] updated at posedge clk:
  - set by rsv_en with rsv_addr = i
  - cleared by wb_en with wb_addr = i
  - reserve and release on the same address in the same cycle: busy ends at 1 (new reservation wins)
  - ZERO_REG = 1: reserve of address 0 is ignored
  - reserve of an already-busy register: busy stays 1, no error
  - wb release of a non-busy register: writes data, busy stays 0
  - port A writes never change busy. A write from port A to a busy register stores the data and leaves busy at 1 (WAW is the issuer's responsibility).
- rs_busy = busy[rsc], and additionally:
  - BYPASS = 1: forced to 0 when wb_en and wb_addr = rsc (same-cycle release)
  - ZERO_REG = 1 and rsc = 0: forced to 0
- rt_busy is defined the same way on rtc.
- busy_cnt: registered population count of busy, updated the same edge as busy. Range 0..2^ADDR_W (reached only when ZERO_REG = 0).
- Latency: write data and busy changes are visible through the registers one cycle after the edge. With BYPASS = 1 they are visible in the same cycle.

Test Plan:
- Reset then read: pulse rst_n low for 2 cycles mid-stream after writing 0xDEADBEEF to r5 → rs = 0 at rsc = 5, busy_cnt = 0, while rst_n is still low.
- Forwarding: BYPASS = 1, wa_en, wa_addr = 7, wa_data = 0x12345678, rsc = 7 in the same cycle → rs = 0x12345678 before the edge. With BYPASS = 0, rs = old value (0) until the next cycle.
- Port conflict: wa and wb both to r9 with data 0xAAAA0000 and 0x5555FFFF → r9 = 0xAAAA0000 next cycle.
- Scoreboard:
  - rsv_en r3 → rs_busy = 1 at rsc = 3 next cycle, busy_cnt = 1
  - wb_en r3 data 0x42 → rs = 0x42 and rs_busy = 0 in the same cycle (BYPASS = 1), busy_cnt = 0 next cycle
  - port A write to r3 while busy → busy stays 1
- Simultaneous reserve + release of r4 → busy[4] = 1 after the edge, busy_cnt unchanged.
- Zero register: ZERO_REG = 1, write 0xFFFFFFFF to r0 via both ports and rsv_en r0 → rs = 0, rs_busy = 0, busy_cnt = 0, all other registers unchanged.
